// File: rtl/target_net_max_unit.sv
// target_net_max_unit
// Streaming max-reduction over NUMBER_OF_OUTPUT_NODE IEEE-754 single-precision
// Q-values. One sample per i_valid beat; the frame maximum is presented on
// o_data with a one-cycle o_valid pulse after the last sample of the frame.
// Optional: define TARGET_MAX_INDEX_EN to add o_index (argmax position,
// earliest index wins on ties).
// Note: rst_n is a synchronous, ACTIVE-HIGH reset despite its name.

module target_net_max_unit #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  localparam int CW = (NUMBER_OF_OUTPUT_NODE > 1) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
`ifdef TARGET_MAX_INDEX_EN
  output logic [CW-1:0]         o_index,
`endif
  output logic                  o_valid
);

  localparam logic [CW-1:0] LAST = CW'(NUMBER_OF_OUTPUT_NODE - 1);

  logic [CW-1:0]         count_q,  count_d;
  logic [DATA_WIDTH-1:0] runMax_q, runMax_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  isLast;
  logic                  takeNew;
  logic [DATA_WIDTH-1:0] candMax;
`ifdef TARGET_MAX_INDEX_EN
  logic [CW-1:0]         runIdx_q, runIdx_d;
  logic [CW-1:0]         index_q,  index_d;
  logic [CW-1:0]         candIdx;
`endif

  // Bit-pattern float ordering: sign decides first (with +0 == -0), then the
  // magnitude field, reversed for negatives. Equal patterns are not greater,
  // and NaN/Inf get no special treatment.
  function automatic logic floatGreater(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] magA;
    logic [DATA_WIDTH-2:0] magB;
    logic                  gt;
    magA = a[DATA_WIDTH-2:0];
    magB = b[DATA_WIDTH-2:0];
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      if ((magA == '0) && (magB == '0)) begin
        gt = 1'b0;
      end else begin
        gt = ~a[DATA_WIDTH-1];
      end
    end else if (!a[DATA_WIDTH-1]) begin
      gt = (magA > magB);
    end else begin
      gt = (magA < magB);
    end
    return gt;
  endfunction

  // Next-state: fold each accepted sample into the running max and close the
  // frame on the last sample; the first sample of a frame always seeds the max.
  always_comb begin
    count_d  = count_q;
    runMax_d = runMax_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    isLast   = (count_q == LAST);
    takeNew  = (count_q == '0) || floatGreater(i_data, runMax_q);
    candMax  = takeNew ? i_data : runMax_q;
`ifdef TARGET_MAX_INDEX_EN
    runIdx_d = runIdx_q;
    index_d  = index_q;
    candIdx  = takeNew ? count_q : runIdx_q;
`endif
    if (i_valid) begin
      runMax_d = candMax;
`ifdef TARGET_MAX_INDEX_EN
      runIdx_d = candIdx;
`endif
      if (isLast) begin
        count_d = '0;
        data_d  = candMax;
        valid_d = 1'b1;
`ifdef TARGET_MAX_INDEX_EN
        index_d = candIdx;
`endif
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // State registers; reset wins over any sample arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_q  <= '0;
      runMax_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef TARGET_MAX_INDEX_EN
      runIdx_q <= '0;
      index_q  <= '0;
`endif
    end else begin
      count_q  <= count_d;
      runMax_q <= runMax_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef TARGET_MAX_INDEX_EN
      runIdx_q <= runIdx_d;
      index_q  <= index_d;
`endif
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
`ifdef TARGET_MAX_INDEX_EN
  assign o_index = index_q;
`endif

endmodule

// File: tb/tb_target_net_max_unit.sv
// Testbench for target_net_max_unit: directed frames plus randomized traffic
// compared against a value-ordering reference model.
`timescale 1ns/1ps

module tb_target_net_max_unit;

  localparam int N  = 3;
  localparam int CW = 2;

  logic        clk;
  logic        rst;
  logic        iValid;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oValid;
`ifdef TARGET_MAX_INDEX_EN
  logic [CW-1:0] oIndex;
`endif

  int passCount  = 0;
  int checkCount = 0;

  target_net_max_unit #(
    .DATA_WIDTH(32),
    .NUMBER_OF_OUTPUT_NODE(N)
  ) dut (
    .clk(clk),
    .rst_n(rst),
    .i_valid(iValid),
    .i_data(iData),
    .o_data(oData),
`ifdef TARGET_MAX_INDEX_EN
    .o_index(oIndex),
`endif
    .o_valid(oValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Numeric ordering key: the signed value of a float is monotonic in its
  // signed-magnitude integer reading (both zeros map to 0).
  function automatic longint floatKey(input logic [31:0] w);
    longint m;
    m = longint'(w[30:0]);
    return w[31] ? -m : m;
  endfunction

  // Reference: maximum of a complete frame, earliest index on ties.
  function automatic void frameMax(input logic [31:0] s[$],
                                   output logic [31:0] best,
                                   output int bestIdx);
    best = s[0];
    bestIdx = 0;
    for (int i = 1; i < s.size(); i++) begin
      if (floatKey(s[i]) > floatKey(best)) begin
        best = s[i];
        bestIdx = i;
      end
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] d);
    iValid = v;
    iData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 32'h4f000000);
    step(1'b0, 32'h0);
    rst = 1'b0;
    checkCount++;
    if (oValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", oValid);
    else passCount++;
    checkCount++;
    if (oData !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 00000000", oData);
    else passCount++;
`ifdef TARGET_MAX_INDEX_EN
    checkCount++;
    if (oIndex !== '0) $display("[TB] FAIL reset_index: got %0d expected 0", oIndex);
    else passCount++;
`endif
  endtask

  task automatic test_directed();
    logic [31:0] frames [4][3];
    logic [31:0] expData [4];
    int          expIdx  [4];
    frames[0] = '{32'h42e26279, 32'h42f3282c, 32'h42c617e1};
    frames[1] = '{32'h42e26279, 32'h42f3282c, 32'h42f40000};
    frames[2] = '{32'hC2000000, 32'h80000000, 32'h00000000};
    frames[3] = '{32'hC1200000, 32'hC0A00000, 32'hC1000000};
    expData = '{32'h42f3282c, 32'h42f40000, 32'h80000000, 32'hC0A00000};
    expIdx  = '{1, 2, 1, 1};
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, frames[f][i]);
        checkCount++;
        if (oValid !== (i == 2)) $display("[TB] FAIL dir_valid f%0d s%0d: got %b expected %b", f, i, oValid, (i == 2));
        else passCount++;
      end
      checkCount++;
      if (oData !== expData[f]) $display("[TB] FAIL dir_data f%0d: got %h expected %h", f, oData, expData[f]);
      else passCount++;
`ifdef TARGET_MAX_INDEX_EN
      checkCount++;
      if (int'(oIndex) !== expIdx[f]) $display("[TB] FAIL dir_index f%0d: got %0d expected %0d", f, oIndex, expIdx[f]);
      else passCount++;
`endif
      for (int g = 0; g < 6; g++) begin
        step(1'b0, $urandom);
        checkCount++;
        if (oValid !== 1'b0 || oData !== expData[f])
          $display("[TB] FAIL dir_hold f%0d c%0d: got v=%b d=%h expected v=0 d=%h", f, g, oValid, oData, expData[f]);
        else passCount++;
      end
    end
  endtask

  task automatic test_gapped();
    logic [31:0] seq [6];
    logic        vld [6];
    seq = '{32'h3F800000, 32'h0, 32'h0, 32'h40000000, 32'h0, 32'h3F000000};
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step(vld[i], seq[i]);
      checkCount++;
      if (oValid !== (i == 5)) $display("[TB] FAIL gap_valid c%0d: got %b expected %b", i, oValid, (i == 5));
      else passCount++;
    end
    checkCount++;
    if (oData !== 32'h40000000) $display("[TB] FAIL gap_data: got %h expected 40000000", oData);
    else passCount++;
`ifdef TARGET_MAX_INDEX_EN
    checkCount++;
    if (oIndex !== 2'd1) $display("[TB] FAIL gap_index: got %0d expected 1", oIndex);
    else passCount++;
`endif
    step(1'b0, 32'h0);
    checkCount++;
    if (oValid !== 1'b0) $display("[TB] FAIL gap_after: got %b expected 0", oValid);
    else passCount++;
  endtask

  task automatic test_mid_reset();
    step(1'b1, 32'h40400000);
    step(1'b1, 32'h40800000);
    rst = 1'b1;
    step(1'b1, 32'h41000000);
    rst = 1'b0;
    checkCount++;
    if (oValid !== 1'b0 || oData !== 32'h0)
      $display("[TB] FAIL midrst_clear: got v=%b d=%h expected v=0 d=00000000", oValid, oData);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h3F800000);
      checkCount++;
      if (oValid !== (i == 2)) $display("[TB] FAIL midrst_valid s%0d: got %b expected %b", i, oValid, (i == 2));
      else passCount++;
    end
    checkCount++;
    if (oData !== 32'h3F800000) $display("[TB] FAIL midrst_data: got %h expected 3F800000", oData);
    else passCount++;
`ifdef TARGET_MAX_INDEX_EN
    checkCount++;
    if (oIndex !== 2'd0) $display("[TB] FAIL midrst_index: got %0d expected 0", oIndex);
    else passCount++;
`endif
    step(1'b0, 32'h0);
    checkCount++;
    if (oValid !== 1'b0) $display("[TB] FAIL midrst_after: got %b expected 0", oValid);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] frame[$];
    logic [31:0] best;
    int          bestIdx;
    for (int i = 0; i < 2 * N; i++) begin
      logic [31:0] d;
      d = $urandom;
      frame.push_back(d);
      step(1'b1, d);
      checkCount++;
      if (oValid !== ((i % N) == N - 1)) $display("[TB] FAIL b2b_valid s%0d: got %b expected %b", i, oValid, ((i % N) == N - 1));
      else passCount++;
      if (frame.size() == N) begin
        frameMax(frame, best, bestIdx);
        frame.delete();
        checkCount++;
        if (oData !== best) $display("[TB] FAIL b2b_data s%0d: got %h expected %h", i, oData, best);
        else passCount++;
`ifdef TARGET_MAX_INDEX_EN
        checkCount++;
        if (int'(oIndex) !== bestIdx) $display("[TB] FAIL b2b_index s%0d: got %0d expected %0d", i, oIndex, bestIdx);
        else passCount++;
`endif
      end
    end
    step(1'b0, 32'h0);
    checkCount++;
    if (oValid !== 1'b0) $display("[TB] FAIL b2b_after: got %b expected 0", oValid);
    else passCount++;
  endtask

  task automatic test_random();
    logic [31:0] frame[$];
    logic [31:0] pool [4];
    logic [31:0] prev;
    logic [31:0] lastData;
    int          lastIdx;
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000};
    prev = 32'h0;
    lastData = oData;
`ifdef TARGET_MAX_INDEX_EN
    lastIdx = int'(oIndex);
`else
    lastIdx = 0;
`endif
    for (int c = 0; c < 300; c++) begin
      logic        v;
      logic [31:0] d;
      logic        expValid;
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       d = pool[$urandom_range(0, 3)];
        1:       d = prev;
        default: d = $urandom;
      endcase
      expValid = 1'b0;
      if (v) begin
        prev = d;
        frame.push_back(d);
        if (frame.size() == N) begin
          frameMax(frame, lastData, lastIdx);
          frame.delete();
          expValid = 1'b1;
        end
      end
      step(v, d);
      checkCount++;
      if (oValid !== expValid || oData !== lastData)
        $display("[TB] FAIL rand c%0d: got v=%b d=%h expected v=%b d=%h", c, oValid, oData, expValid, lastData);
      else passCount++;
`ifdef TARGET_MAX_INDEX_EN
      checkCount++;
      if (int'(oIndex) !== lastIdx) $display("[TB] FAIL rand_index c%0d: got %0d expected %0d", c, oIndex, lastIdx);
      else passCount++;
`endif
    end
  endtask

  initial begin
    rst    = 1'b0;
    iValid = 1'b0;
    iData  = 32'h0;
    test_reset();
    test_directed();
    test_gapped();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/target_net_max_unit.md
Name: target_net_max_unit

Overview:
- Streaming max-reduction unit for the target Q-network output layer.
- Accepts NUMBER_OF_OUTPUT_NODE IEEE-754 single-precision Q-values, one per i_valid beat, and emits the largest value as a one-cycle o_valid pulse.
- Sits between the target-network output RAM reader and the Bellman target computation (r + gamma*max Q').
- Purely combinational float compare plus running-max register; no FP arithmetic.

Parameters:
- DATA_WIDTH, 32: word width; IEEE-754 single layout (1 sign, 8 exponent, 23 mantissa); only 32 supported.
- NUMBER_OF_OUTPUT_NODE, 3: values per frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-high (reset when 1, sampled on the clk edge).
- i_valid  input  1  i_data carries a sample this cycle.
- i_data  input  DATA_WIDTH  float sample.
- o_data  output  DATA_WIDTH  frame maximum.
- o_valid  output  1  one-cycle pulse; o_data valid.

Behaviour:
- Reset (rst_n=1 at an edge) clears the following, overriding all other activity, including mid-frame: sample counter=0, running max=0, o_data=0, o_valid=0.
- Sample counter width = max(1, clog2(NUMBER_OF_OUTPUT_NODE)); it counts accepted samples only.
- i_valid gaps inside a frame are allowed; the frame state holds while i_valid=0.
- Accepting a sample (i_valid=1 at an edge):
  - First sample of a frame (count==0): running max <= i_data.
  - Later samples: running max <= i_data only if i_data is strictly greater than the running max. Ties keep the earlier value.
  - Count increments on each accepted sample.
  - On the sample with count==N-1:
    - o_data <= max(running, i_data), using the same strict-greater rule.
    - o_valid <= 1.
    - Count <= 0.
  - For N=1, every accepted sample produces a result equal to i_data.
- Latency: o_valid is high for exactly the one cycle after the edge that accepted the last sample.
  - Otherwise o_valid=0.
  - o_data holds its value until the next result or reset.
- Back-to-back frames: the first sample of the next frame may arrive in the same cycle o_valid is high, with no bubble required.
- Float compare (combinational, a > b):
  - Signs differ: the positive operand is greater. +0 and -0 compare equal.
  - Both positive: greater unsigned {exp,mant} is greater.
  - Both negative: smaller unsigned {exp,mant} is greater.
  - Equal bit patterns: not greater.
  - NaN/Inf are treated by the same bit-pattern rule; no special casing.
- No backpressure; input is always accepted.

Optional Feature:
- Macro TARGET_MAX_INDEX_EN.
- Defined:
  - Adds output o_index, width max(1, clog2(NUMBER_OF_OUTPUT_NODE)), giving the 0-based position within the frame of the winning sample (argmax; earliest index on ties).
  - o_index is updated alongside o_data and reset to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then frame 42e26279, 42f3282c, 42c617e1 on consecutive cycles -> single o_valid pulse one cycle after the third sample, o_data=42f3282c (index 1 with TARGET_MAX_INDEX_EN).
- After 6 idle cycles, frame 42e26279, 42f3282c, 42f40000 -> o_data=42f40000 (index 2); o_data holds 42f3282c until then.
- Mixed signs C2000000, 80000000, 00000000 -> o_data=80000000 (ties: -0 == +0 keeps earlier; -0 > -32). All-negative C1200000, C0A00000, C1000000 -> o_data=C0A00000.
- Gapped input: samples 3F800000, idle 2 cycles, 40000000, idle 1 cycle, 3F000000 -> o_data=40000000, pulse only after the third sample.
- Reset asserted after 2 samples of a frame, then full frame 3F800000, 3F800000, 3F800000 -> exactly one pulse, o_data=3F800000 (index 0), no stale carry-over.
- Back-to-back frames with zero gap (6 consecutive samples) -> two pulses exactly 3 cycles apart with the correct per-frame maxima.
